alu_share_scheduler: RTL and testbench



---
 rtl/alu_share_pkg.sv | 18 +
 rtl/alu_share_if.sv | 36 +++
 rtl/alu_share_datapath.sv | 99 +++++++++
 rtl/alu_share_scheduler.sv | 92 +++++++++
 tb/tb_alu_share_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared constants for the stereo ALU-sharing scheduler: opcodes, channel
// tags, default datapath width and saturation limits.
package alu_share_pkg;

  localparam int DW_DEF = 40;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_SHR    = 2'b10;
  localparam logic [1:0] OP_ADDSHR = 2'b11;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  localparam logic [DW_DEF-1:0] SAT_POS = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam logic [DW_DEF-1:0] SAT_NEG = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/alu_share_if.sv
// Channel bus between the left/right accumulation controllers (master)
// and the shared ALU scheduler (slave).
interface alu_share_if #(parameter int DW = 40);

  logic          alu_en;
  logic          frame_sync;
  logic          reqL;
  logic [1:0]    opL;
  logic [DW-1:0] aL;
  logic [DW-1:0] bL;
  logic          gntL;
  logic          vldL;
  logic [DW-1:0] resL;
  logic          reqR;
  logic [1:0]    opR;
  logic [DW-1:0] aR;
  logic [DW-1:0] bR;
  logic          gntR;
  logic          vldR;
  logic [DW-1:0] resR;
  logic          busy;
  logic          ovf;

  modport master (
    output alu_en, frame_sync,
    output reqL, opL, aL, bL, reqR, opR, aR, bR,
    input  gntL, vldL, resL, gntR, vldR, resR, busy, ovf
  );

  modport slave (
    input  alu_en, frame_sync,
    input  reqL, opL, aL, bL, reqR, opR, aR, bR,
    output gntL, vldL, resL, gntR, vldR, resR, busy, ovf
  );

endinterface

// File: rtl/alu_share_datapath.sv
// Shared add/sub/shift pipeline. Carries {valid, tag, op, A, B} through
// PIPE_STAGES registers and evaluates the operation on the last stage.
// Build option: ALU_SHARE_SAT_EN saturates ADD/SUB overflow instead of wrapping.
module alu_share_datapath
  import alu_share_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 Sclk,
  input  logic                 Reset_n,
  input  logic                 cap_vld,
  input  logic                 cap_tag,
  input  logic [1:0]           cap_op,
  input  logic signed [DW-1:0] cap_a,
  input  logic signed [DW-1:0] cap_b,
  output logic                 res_vld,
  output logic                 res_tag,
  output logic signed [DW-1:0] res,
  output logic                 res_ovf,
  output logic                 busy
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] vld_p;
  logic                   tag_p [PIPE_STAGES];
  logic [1:0]             op_p  [PIPE_STAGES];
  logic signed [DW-1:0]   a_p   [PIPE_STAGES];
  logic signed [DW-1:0]   b_p   [PIPE_STAGES];

  logic signed [DW:0] a_w, b_w, sum_w, dif_w;

`ifdef ALU_SHARE_SAT_EN
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

  // Clamp a DW+1 bit signed result back to DW bits (wrap or saturate).
  function automatic logic signed [DW-1:0] fit_dw(input logic signed [DW:0] wide);
    logic signed [DW-1:0] r;
    r = wide[DW-1:0];
`ifdef ALU_SHARE_SAT_EN
    if (wide[DW] != wide[DW-1]) r = wide[DW] ? SAT_MIN : SAT_MAX;
`endif
    return r;
  endfunction

  // Stage valid bits: the only state cleared by reset.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= cap_vld;
      for (int i = 1; i < PIPE_STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Operand pipeline: capture at stage 0, shift forward each cycle.
  always_ff @(posedge Sclk) begin
    tag_p[0] <= cap_tag;
    op_p[0]  <= cap_op;
    a_p[0]   <= cap_a;
    b_p[0]   <= cap_b;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      tag_p[i] <= tag_p[i-1];
      op_p[i]  <= op_p[i-1];
      a_p[i]   <= a_p[i-1];
      b_p[i]   <= b_p[i-1];
    end
  end

  // Last stage: evaluate the operation in DW+1 bits and flag overflow.
  always_comb begin
    a_w     = {a_p[LAST][DW-1], a_p[LAST]};
    b_w     = {b_p[LAST][DW-1], b_p[LAST]};
    sum_w   = a_w + b_w;
    dif_w   = a_w - b_w;
    res     = '0;
    res_ovf = 1'b0;
    case (op_p[LAST])
      OP_ADD: begin
        res     = fit_dw(sum_w);
        res_ovf = vld_p[LAST] & (sum_w[DW] ^ sum_w[DW-1]);
      end
      OP_SUB: begin
        res     = fit_dw(dif_w);
        res_ovf = vld_p[LAST] & (dif_w[DW] ^ dif_w[DW-1]);
      end
      OP_SHR:  res = a_p[LAST] >>> 1;
      default: res = sum_w[DW:1];
    endcase
  end

  assign res_vld = vld_p[LAST];
  assign res_tag = tag_p[LAST];
  assign busy    = |vld_p;

endmodule

// File: rtl/alu_share_scheduler.sv
// Round-robin scheduler sharing one add/sub/shift pipeline between the left
// and right accumulation controllers; routes results back as valid pulses
// and keeps a sticky overflow flag cleared by frame_sync.
// Build option: ALU_SHARE_SAT_EN (saturating ADD/SUB, see alu_share_datapath).
module alu_share_scheduler
  import alu_share_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int PIPE_STAGES = 2
) (
  input logic       Sclk,
  input logic       Reset_n,
  alu_share_if.slave bus
);

  logic          ptr;
  logic          elig_l, elig_r, grant_l, grant_r;
  logic          cap_vld, cap_tag;
  logic [1:0]    cap_op;
  logic [DW-1:0] cap_a, cap_b;
  logic          res_vld, res_tag, res_ovf;
  logic [DW-1:0] res;

  // Arbitration: a channel is eligible unless it was granted last edge.
  always_comb begin
    elig_l  = bus.reqL & ~bus.gntL;
    elig_r  = bus.reqR & ~bus.gntR;
    grant_l = 1'b0;
    grant_r = 1'b0;
    if (bus.alu_en) begin
      if (elig_l && (!elig_r || ptr == CH_L)) grant_l = 1'b1;
      else if (elig_r)                        grant_r = 1'b1;
    end
    cap_vld = grant_l | grant_r;
    cap_tag = grant_r ? CH_R : CH_L;
    cap_op  = grant_r ? bus.opR : bus.opL;
    cap_a   = grant_r ? bus.aR  : bus.aL;
    cap_b   = grant_r ? bus.bR  : bus.bL;
  end

  // Grant pulses and round-robin pointer; frame_sync overrides the pointer.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.gntL <= 1'b0;
      bus.gntR <= 1'b0;
      ptr      <= CH_L;
    end else begin
      bus.gntL <= grant_l;
      bus.gntR <= grant_r;
      if (bus.frame_sync) ptr <= CH_L;
      else if (grant_l)   ptr <= CH_R;
      else if (grant_r)   ptr <= CH_L;
    end
  end

  // Result routing to the requesting channel, plus sticky overflow.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.vldL <= 1'b0;
      bus.vldR <= 1'b0;
      bus.resL <= '0;
      bus.resR <= '0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.vldL <= res_vld & (res_tag == CH_L);
      bus.vldR <= res_vld & (res_tag == CH_R);
      if (res_vld && res_tag == CH_L) bus.resL <= res;
      if (res_vld && res_tag == CH_R) bus.resR <= res;
      if (res_ovf)             bus.ovf <= 1'b1;
      else if (bus.frame_sync) bus.ovf <= 1'b0;
    end
  end

  alu_share_datapath #(
    .DW          (DW),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_datapath (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .cap_vld (cap_vld),
    .cap_tag (cap_tag),
    .cap_op  (cap_op),
    .cap_a   (cap_a),
    .cap_b   (cap_b),
    .res_vld (res_vld),
    .res_tag (res_tag),
    .res     (res),
    .res_ovf (res_ovf),
    .busy    (bus.busy)
  );

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Bench for alu_share_scheduler: directed scenarios followed by randomized
// traffic, all compared each cycle against a transaction-level model.
module tb_alu_share_scheduler;
  import alu_share_pkg::*;

  localparam int DW = 40;
  localparam int PS = 2;
  localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW-1));

  logic Sclk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Sclk = ~Sclk;

  alu_share_if #(.DW(DW)) bus();

  alu_share_scheduler #(.DW(DW), .PIPE_STAGES(PS)) dut (
    .Sclk    (Sclk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int            due;
    bit            ch;
    logic [DW-1:0] res;
    bit            ovf;
  } pend_t;

  pend_t         pq[$];
  int            edge_no = 0;
  int            checks = 0;
  int            failures = 0;
  bit            m_gntL, m_gntR, m_vldL, m_vldR, m_ovf, m_busy, m_ptr;
  logic [DW-1:0] m_resL, m_resR;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, edge_no, got, exp);
    end
  endtask

  // Arithmetic reference in 64-bit signed integers.
  function automatic void ref_alu(input logic [1:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [DW-1:0] r,
                                  output bit ov);
    longint sa, sb, w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD:  w = sa + sb;
      OP_SUB:  w = sa - sb;
      OP_SHR:  w = sa >>> 1;
      default: w = (sa + sb) >>> 1;
    endcase
    ov = (op == OP_ADD || op == OP_SUB) && (w > MAXV || w < MINV);
    r  = w[DW-1:0];
`ifdef ALU_SHARE_SAT_EN
    if (ov) r = (w > 0) ? SAT_POS : SAT_NEG;
`endif
  endfunction

  task automatic model_reset();
    pq.delete();
    m_gntL = 0; m_gntR = 0; m_vldL = 0; m_vldR = 0;
    m_ovf = 0; m_busy = 0; m_ptr = CH_L;
    m_resL = '0; m_resR = '0;
  endtask

  task automatic model_edge();
    bit eL, eR, gL, gR, ov, hit;
    logic [DW-1:0] r;
    pend_t p;
    edge_no++;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    eL = bus.reqL && !m_gntL;
    eR = bus.reqR && !m_gntR;
    gL = 0;
    gR = 0;
    if (bus.alu_en) begin
      if (eL && eR) begin
        if (m_ptr == CH_L) gL = 1; else gR = 1;
      end else begin
        gL = eL;
        gR = eR;
      end
    end
    if (gL) begin
      ref_alu(bus.opL, bus.aL, bus.bL, r, ov);
      pq.push_back('{due: edge_no + PS, ch: CH_L, res: r, ovf: ov});
    end
    if (gR) begin
      ref_alu(bus.opR, bus.aR, bus.bR, r, ov);
      pq.push_back('{due: edge_no + PS, ch: CH_R, res: r, ovf: ov});
    end
    m_gntL = gL;
    m_gntR = gR;
    if (gL) m_ptr = CH_R;
    if (gR) m_ptr = CH_L;
    if (bus.frame_sync) m_ptr = CH_L;
    m_vldL = 0;
    m_vldR = 0;
    hit = 0;
    if (pq.size() > 0 && pq[0].due == edge_no) begin
      p = pq.pop_front();
      if (p.ch == CH_L) begin m_vldL = 1; m_resL = p.res; end
      else              begin m_vldR = 1; m_resR = p.res; end
      hit = p.ovf;
    end
    if (hit) m_ovf = 1;
    else if (bus.frame_sync) m_ovf = 0;
    m_busy = (pq.size() > 0);
  endtask

  task automatic compare_all();
    check("gntL", bus.gntL, m_gntL);
    check("gntR", bus.gntR, m_gntR);
    check("vldL", bus.vldL, m_vldL);
    check("vldR", bus.vldR, m_vldR);
    check("resL", bus.resL, m_resL);
    check("resR", bus.resR, m_resR);
    check("busy", bus.busy, m_busy);
    check("ovf",  bus.ovf,  m_ovf);
  endtask

  // One clock: model the edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge Sclk);
    model_edge();
    @(negedge Sclk);
    compare_all();
  endtask

  function automatic logic [DW-1:0] rnd_opnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return SAT_POS;
      1:       return SAT_NEG;
      2:       return t[DW-1:0] & 'hFF;
      default: return t[DW-1:0];
    endcase
  endfunction

  task automatic drive_chan(input bit ch);
    bit act;
    if (ch == CH_L) begin
      if (bus.reqL) begin
        if (m_gntL) begin
          act = bit'($urandom_range(0, 1));
          bus.reqL = act;
          if (act) begin
            bus.opL = 2'($urandom_range(0, 3)); bus.aL = rnd_opnd(); bus.bL = rnd_opnd();
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.reqL = 1; bus.opL = 2'($urandom_range(0, 3)); bus.aL = rnd_opnd(); bus.bL = rnd_opnd();
      end
    end else begin
      if (bus.reqR) begin
        if (m_gntR) begin
          act = bit'($urandom_range(0, 1));
          bus.reqR = act;
          if (act) begin
            bus.opR = 2'($urandom_range(0, 3)); bus.aR = rnd_opnd(); bus.bR = rnd_opnd();
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.reqR = 1; bus.opR = 2'($urandom_range(0, 3)); bus.aR = rnd_opnd(); bus.bR = rnd_opnd();
      end
    end
  endtask

  task automatic drop_granted();
    if (m_gntL) bus.reqL = 0;
    if (m_gntR) bus.reqR = 0;
  endtask

  // Issue a lone left-channel operation and stop on its vldL cycle.
  task automatic run_left(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.reqL = 1; bus.opL = op; bus.aL = a; bus.bL = b;
    cycle();
    check("run_gntL", bus.gntL, 1);
    bus.reqL = 0;
    repeat (PS) cycle();
    check("run_vldL", bus.vldL, 1);
  endtask

  initial begin
    bus.alu_en = 1; bus.frame_sync = 0;
    bus.reqL = 0; bus.opL = 0; bus.aL = 0; bus.bL = 0;
    bus.reqR = 0; bus.opR = 0; bus.aR = 0; bus.bR = 0;
    model_reset();

    // Reset held with random requests
    for (int i = 0; i < 4; i++) begin
      bus.reqL = 1'($urandom_range(0, 1)); bus.reqR = 1'($urandom_range(0, 1));
      cycle();
    end
    Reset_n = 1;

    // First conflict grants L, then R; results in the same order
    bus.reqL = 1; bus.opL = OP_ADD; bus.aL = 10; bus.bL = 1;
    bus.reqR = 1; bus.opR = OP_SUB; bus.aR = 10; bus.bR = 1;
    cycle();
    check("conf_gntL", bus.gntL, 1);
    drop_granted();
    cycle();
    check("conf_gntR", bus.gntR, 1);
    drop_granted();
    cycle();
    check("conf_vldL", bus.vldL, 1);
    cycle();
    check("conf_vldR", bus.vldR, 1);
    check("conf_resR", bus.resR, 9);
    repeat (2) cycle();

    // R alone moves the pointer to L; the next conflict goes to L
    bus.reqR = 1; bus.opR = OP_ADD; bus.aR = 2; bus.bR = 2;
    cycle();
    check("ralone_gntR", bus.gntR, 1);
    bus.reqR = 0;
    cycle();
    bus.reqL = 1; bus.reqR = 1;
    cycle();
    check("conf2_gntL", bus.gntL, 1);
    drop_granted();
    cycle();
    drop_granted();
    repeat (4) cycle();

    // Single left add
    bus.reqL = 1; bus.opL = OP_ADD; bus.aL = 5; bus.bL = 3;
    cycle();
    check("add_gntL", bus.gntL, 1);
    check("add_busy0", bus.busy, 1);
    bus.reqL = 0;
    cycle();
    check("add_busy1", bus.busy, 1);
    cycle();
    check("add_vldL", bus.vldL, 1);
    check("add_resL", bus.resL, 8);
    check("add_vldR", bus.vldR, 0);
    cycle();

    // Add-shift and arithmetic shift
    run_left(OP_ADDSHR, SAT_POS, 1);
    check("addshr_res", bus.resL, 40'h4000000000);
    check("addshr_ovf", bus.ovf, 0);
    run_left(OP_SHR, SAT_NEG, 0);
    check("shr_res", bus.resL, 40'hC000000000);

    // Overflow, sticky, cleared by frame_sync
    run_left(OP_ADD, SAT_POS, 1);
`ifdef ALU_SHARE_SAT_EN
    check("ovf_res", bus.resL, 40'h7FFFFFFFFF);
`else
    check("ovf_res", bus.resL, 40'h8000000000);
`endif
    check("ovf_set", bus.ovf, 1);
    repeat (3) cycle();
    check("ovf_sticky", bus.ovf, 1);
    bus.frame_sync = 1;
    cycle();
    bus.frame_sync = 0;
    check("ovf_clr", bus.ovf, 0);

    // Reset mid-operation
    bus.reqL = 1; bus.opL = OP_ADD; bus.aL = 7; bus.bL = 7;
    cycle();
    bus.reqL = 0;
    cycle();
    Reset_n = 0;
    #1;
    model_reset();
    compare_all();
    check("rst_busy", bus.busy, 0);
    cycle();
    check("rst_novld", bus.vldL, 0);
    Reset_n = 1;
    run_left(OP_SUB, 20, 5);
    check("post_rst_res", bus.resL, 15);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.alu_en     = ($urandom_range(0, 7) != 0);
      bus.frame_sync = ($urandom_range(0, 19) == 0);
      drive_chan(CH_L);
      drive_chan(CH_R);
      cycle();
    end
    bus.reqL = 0; bus.reqR = 0; bus.frame_sync = 0;
    repeat (PS + 2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
